// File: rtl/tlb_mmu_pkg.sv
// Shared TLB definitions: CP0 op codes, exception codes, segment decode and EntryHi/EntryLo field positions.
package tlb_mmu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_TLBWI = 3'b001,
    OP_TLBWR = 3'b010,
    OP_TLBP  = 3'b011,
    OP_TLBR  = 3'b100
  } tlb_op_e;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_REFILL  = 2'b01,
    EXC_INVALID = 2'b10,
    EXC_MOD     = 2'b11
  } tlb_exc_e;

  // Unmapped segments are identified by va[31:29]
  localparam logic [2:0] KSEG0_TOP = 3'b100;
  localparam logic [2:0] KSEG1_TOP = 3'b101;

  localparam int LO_G       = 0;
  localparam int LO_V       = 1;
  localparam int LO_D       = 2;
  localparam int LO_C_LSB   = 3;
  localparam int LO_PFN_LSB = 6;
  localparam int HI_VPN2_LSB = 13;

  function automatic logic is_kseg0(input logic [31:0] va);
    return va[31:29] == KSEG0_TOP;
  endfunction

  function automatic logic is_kseg1(input logic [31:0] va);
    return va[31:29] == KSEG1_TOP;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Combinational CAM compare over all TLB entries with lowest-index priority encode.
// TLB_ASID_EN: when defined, a match also requires G=1 or an ASID equal to the key ASID.
module tlb_match #(
  parameter int ENTRIES = 16,
  parameter int VPN2_W  = 19,
  parameter int ASID_W  = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] ent_valid,
  input  logic [VPN2_W-1:0]  ent_vpn2 [ENTRIES],
  input  logic [ASID_W-1:0]  ent_asid [ENTRIES],
  input  logic [ENTRIES-1:0] ent_g,
  input  logic [VPN2_W-1:0]  key_vpn2,
  input  logic [ASID_W-1:0]  key_asid,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  logic [ENTRIES-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
`ifdef TLB_ASID_EN
      match[i] = ent_valid[i] && (ent_vpn2[i] == key_vpn2) &&
                 (ent_g[i] || (ent_asid[i] == key_asid));
`else
      match[i] = ent_valid[i] && (ent_vpn2[i] == key_vpn2);
`endif
    end
  end

`ifndef TLB_ASID_EN
  // ASID/G do not take part in matching in this build
  logic [ENTRIES-1:0] unused_asid_red;
  logic               unused_asid_key;
  always_comb begin
    unused_asid_red = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      unused_asid_red[i] = (^ent_asid[i]) ^ ent_g[i];
    end
  end
  assign unused_asid_key = ^key_asid;
`endif

  // Scan downwards so the lowest matching index is the one left in idx
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tlb_mmu.sv
// Fully-associative MIPS32-style TLB: registered translate port, TLBWI/TLBWR/TLBP/TLBR, Random counter with Wired.
// TLB_ASID_EN: when defined, matching honours ASID and the global bit; otherwise ASID/G are stored only.
module tlb_mmu
  import tlb_mmu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int VPN2_W  = 19,
  parameter int PFN_W   = 20,
  parameter int ASID_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic [31:0]      req_vaddr_i,
  input  logic             req_store_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_paddr_o,
  output logic [1:0]       resp_exc_o,
  input  logic [2:0]       op_i,
  input  logic [31:0]      entryhi_i,
  input  logic [31:0]      entrylo0_i,
  input  logic [31:0]      entrylo1_i,
  input  logic [IDX_W-1:0] index_i,
  input  logic [IDX_W-1:0] wired_i,
  output logic [IDX_W-1:0] random_o,
  output logic             op_done_o,
  output logic [31:0]      probe_o,
  output logic [31:0]      rd_hi_o,
  output logic [31:0]      rd_lo0_o,
  output logic [31:0]      rd_lo1_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W:0]   ONE_W    = (IDX_W + 1)'(1);

  logic [ENTRIES-1:0] ent_valid;
  logic [VPN2_W-1:0]  ent_vpn2 [ENTRIES];
  logic [ASID_W-1:0]  ent_asid [ENTRIES];
  logic [ENTRIES-1:0] ent_g;
  logic [PFN_W-1:0]   ent_pfn0 [ENTRIES];
  logic [PFN_W-1:0]   ent_pfn1 [ENTRIES];
  logic [2:0]         ent_c0   [ENTRIES];
  logic [2:0]         ent_c1   [ENTRIES];
  logic [ENTRIES-1:0] ent_d0, ent_v0, ent_d1, ent_v1;

  logic [VPN2_W-1:0] hi_vpn2;
  logic [ASID_W-1:0] hi_asid;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  random_nxt;

  assign hi_vpn2 = entryhi_i[31 -: VPN2_W];
  assign hi_asid = entryhi_i[ASID_W-1:0];
  assign wr_en   = (op_i == OP_TLBWI) || (op_i == OP_TLBWR);
  assign wr_idx  = (op_i == OP_TLBWR) ? random_o : index_i;

  logic unused_bits;
  assign unused_bits = ^{entryhi_i[HI_VPN2_LSB-1:ASID_W],
                         entrylo0_i[31:LO_PFN_LSB+PFN_W],
                         entrylo1_i[31:LO_PFN_LSB+PFN_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
    end else if (wr_en) begin
      ent_valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      ent_vpn2[wr_idx] <= hi_vpn2;
      ent_asid[wr_idx] <= hi_asid;
      ent_g[wr_idx]    <= entrylo0_i[LO_G] & entrylo1_i[LO_G];
      ent_pfn0[wr_idx] <= entrylo0_i[LO_PFN_LSB +: PFN_W];
      ent_c0[wr_idx]   <= entrylo0_i[LO_C_LSB +: 3];
      ent_d0[wr_idx]   <= entrylo0_i[LO_D];
      ent_v0[wr_idx]   <= entrylo0_i[LO_V];
      ent_pfn1[wr_idx] <= entrylo1_i[LO_PFN_LSB +: PFN_W];
      ent_c1[wr_idx]   <= entrylo1_i[LO_C_LSB +: 3];
      ent_d1[wr_idx]   <= entrylo1_i[LO_D];
      ent_v1[wr_idx]   <= entrylo1_i[LO_V];
    end
  end

  logic             tr_hit, pr_hit;
  logic [IDX_W-1:0] tr_idx, pr_idx;

  tlb_match #(
    .ENTRIES(ENTRIES), .VPN2_W(VPN2_W), .ASID_W(ASID_W), .IDX_W(IDX_W)
  ) u_match_tr (
    .ent_valid(ent_valid), .ent_vpn2(ent_vpn2), .ent_asid(ent_asid), .ent_g(ent_g),
    .key_vpn2(req_vaddr_i[31 -: VPN2_W]), .key_asid(hi_asid),
    .hit(tr_hit), .idx(tr_idx)
  );

  tlb_match #(
    .ENTRIES(ENTRIES), .VPN2_W(VPN2_W), .ASID_W(ASID_W), .IDX_W(IDX_W)
  ) u_match_pr (
    .ent_valid(ent_valid), .ent_vpn2(ent_vpn2), .ent_asid(ent_asid), .ent_g(ent_g),
    .key_vpn2(hi_vpn2), .key_asid(hi_asid),
    .hit(pr_hit), .idx(pr_idx)
  );

  logic [PFN_W-1:0] sel_pfn;
  logic             sel_v, sel_d;
  logic [31:0]      tr_paddr;
  tlb_exc_e         tr_exc;

  // va[12] picks the odd page of the pair
  always_comb begin
    sel_pfn  = req_vaddr_i[12] ? ent_pfn1[tr_idx] : ent_pfn0[tr_idx];
    sel_v    = req_vaddr_i[12] ? ent_v1[tr_idx]   : ent_v0[tr_idx];
    sel_d    = req_vaddr_i[12] ? ent_d1[tr_idx]   : ent_d0[tr_idx];
    tr_paddr = '0;
    tr_exc   = EXC_NONE;
    if (is_kseg0(req_vaddr_i)) begin
      tr_paddr = {1'b0, req_vaddr_i[30:0]};
    end else if (is_kseg1(req_vaddr_i)) begin
      tr_paddr = {3'b000, req_vaddr_i[28:0]};
    end else if (!tr_hit) begin
      tr_exc = EXC_REFILL;
    end else if (!sel_v) begin
      tr_exc = EXC_INVALID;
    end else if (req_store_i && !sel_d) begin
      tr_exc = EXC_MOD;
    end else begin
      tr_paddr = 32'({sel_pfn, req_vaddr_i[11:0]});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_o <= 1'b0;
      resp_paddr_o <= '0;
      resp_exc_o   <= EXC_NONE;
    end else begin
      resp_valid_o <= req_valid_i;
      if (req_valid_i) begin
        resp_paddr_o <= tr_paddr;
        resp_exc_o   <= tr_exc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_done_o <= 1'b0;
      probe_o   <= '0;
      rd_hi_o   <= '0;
      rd_lo0_o  <= '0;
      rd_lo1_o  <= '0;
    end else begin
      op_done_o <= (op_i == OP_TLBP) || (op_i == OP_TLBR);
      if (op_i == OP_TLBP) begin
        probe_o <= pr_hit ? 32'(pr_idx) : 32'h8000_0000;
      end
      if (op_i == OP_TLBR) begin
        rd_hi_o  <= {ent_vpn2[index_i], {(HI_VPN2_LSB - ASID_W){1'b0}}, ent_asid[index_i]};
        rd_lo0_o <= 32'({ent_pfn0[index_i], ent_c0[index_i], ent_d0[index_i],
                         ent_v0[index_i], ent_g[index_i]});
        rd_lo1_o <= 32'({ent_pfn1[index_i], ent_c1[index_i], ent_d1[index_i],
                         ent_v1[index_i], ent_g[index_i]});
      end
    end
  end

  // Random never lands on a wired slot: reload as soon as the next value would be <= Wired
  always_comb begin
    if ((wired_i >= LAST_IDX) || ({1'b0, random_o} <= ({1'b0, wired_i} + ONE_W))) begin
      random_nxt = LAST_IDX;
    end else begin
      random_nxt = random_o - IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      random_o <= LAST_IDX;
    end else begin
      random_o <= random_nxt;
    end
  end

endmodule
